mdu: RTL

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the cotm32 core. It sits beside the combinational `alu` in the execute stage and takes multi-cycle ops off the single-cycle path. Operands are accepted and results returned over valid/ready handshakes. Width and bits-per-cycle are parameters, and the execute stage can flush it.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_step.sv | 47 ++++
 rtl/mdu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit.
//   mdu_op_t   : RV32M operation select (3 bits)
//   op_is_div  : true for DIV/DIVU/REM/REMU
//   a_signed   : rs1 is treated as a signed operand
//   b_signed   : rs2 is treated as a signed operand
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdu_op_t;

  function automatic logic op_is_div(mdu_op_t op);
    return op[2];
  endfunction

  // MUL only needs the low half, which is the same for signed and unsigned inputs.
  function automatic logic a_signed(mdu_op_t op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic b_signed(mdu_op_t op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the iterative multiply/divide datapath,
// retiring STEP bits.
//   acc_i    : 2*XLEN accumulator. Multiply: {partial, multiplier}.
//              Divide: {remainder, dividend/quotient}.
//   opd_i    : multiplicand (multiply) or divisor (divide), as magnitudes
//   is_div_i : select restoring divide instead of shift-add multiply
//   acc_o    : accumulator after STEP iterations
module mdu_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem_t;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;

  always_comb begin
    acc   = acc_i;
    rem_t = '0;
    diff  = '0;
    sum   = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (is_div_i) begin
        // Shifted remainder can exceed XLEN bits, so trial-subtract in XLEN+1.
        rem_t = acc[2*XLEN-1:XLEN-1];
        diff  = rem_t - {1'b0, opd_i};
        if (!diff[XLEN]) begin
          acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
          acc = {acc[2*XLEN-2:0], 1'b0};
        end
      end else begin
        // Multiplier bits sit in the low half and are consumed LSB first.
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd_i} : '0);
        acc = {sum, acc[XLEN-1:1]};
      end
    end
    acc_o = acc;
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_valid / o_ready   : request handshake (accepted only in IDLE)
//   i_a, i_b, i_op      : rs1, rs2, operation
//   i_flush             : abort any in-flight op; wins over a same-cycle request
//   o_valid / i_ready   : result handshake
//   o_result            : result, held stable while o_valid is high
// Operates on magnitudes; the result sign is applied once after XLEN/STEP iterations.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  mdu_op_t         i_op,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned N    = XLEN / STEP;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t            state_q;
  mdu_op_t           op_q;
  logic [XLEN-1:0]   opd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  // Request-side decode
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    a_neg    = a_signed(i_op) & i_a[XLEN-1];
    b_neg    = b_signed(i_op) & i_b[XLEN-1];
    a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
    b_mag    = b_neg ? (~i_b + 1'b1) : i_b;
    div_zero = op_is_div(i_op) && (i_b == '0);
    div_ovf  = ((i_op == OpDiv) || (i_op == OpRem)) && (i_a == MinVal) && (i_b == '1);
    fast_result = '0;
    unique case (i_op)
      OpDiv, OpDivu: fast_result = div_zero ? '1 : MinVal;
      OpRem, OpRemu: fast_result = div_zero ? i_a : '0;
      default:       fast_result = '0;
    endcase
  end

  logic              step_div;
  logic [2*XLEN-1:0] acc_next;

  assign step_div = op_is_div(op_q);

  mdu_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .acc_i    (acc_q),
    .opd_i    (opd_q),
    .is_div_i (step_div),
    .acc_o    (acc_next)
  );

  // Sign fix-up and result selection on the final iteration's output
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    prod = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    final_result = '0;
    unique case (op_q)
      OpMul:                     final_result = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_result = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             final_result = neg_q ? (~quo + 1'b1) : quo;
      OpRem, OpRemu:             final_result = neg_q ? (~rem + 1'b1) : rem;
      default:                   final_result = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      opd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (i_flush) begin
      state_q  <= StIdle;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            op_q  <= i_op;
            cnt_q <= '0;
            // REM follows the dividend's sign; everything else the product of signs.
            neg_q <= (i_op == OpRem) ? a_neg : (a_neg ^ b_neg);
            if (div_zero || div_ovf) begin
              result_q <= fast_result;
              state_q  <= StDone;
            end else begin
              if (op_is_div(i_op)) begin
                opd_q <= b_mag;
                acc_q <= {{XLEN{1'b0}}, a_mag};
              end else begin
                opd_q <= a_mag;
                acc_q <= {{XLEN{1'b0}}, b_mag};
              end
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            result_q <= final_result;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready  = (state_q == StIdle);
  assign o_valid  = (state_q == StDone);
  assign o_result = result_q;

endmodule
